txuart_stream: RTL

UART 8N1 transmitter with a sample FIFO. It streams audio or other multi-byte samples from the fabric to a host over RS232. It is the transmit counterpart of the board's UART receiver path: samples are accepted with a valid/ready handshake, buffered, split into bytes least-significant byte first, and serialized back to back. The host can then reassemble samples in the same byte order the receiver path uses.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/txuart_stream.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive sample paths:
// line levels, frame size, FSM state encoding and the board baud divide.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_t;

   localparam int   UART_DATA_BITS = 8;
   localparam logic START_LEVEL    = 1'b0;
   localparam logic STOP_LEVEL     = 1'b1;

   // 12 MHz board clock, 115200 baud host link -> 104 clocks per bit
   localparam int UART_CLK_HZ         = 12_000_000;
   localparam int UART_BAUD           = 115_200;
   localparam int UART_DEFAULT_DIVIDE = UART_CLK_HZ / UART_BAUD;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. Read data is the head entry
// presented combinationally (no look-ahead register), so a pop consumes
// exactly what rd_data shows in that cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   localparam int DEPTH = 1 << AW;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // Storage array: data only, never reset
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   // Pointers and occupancy; simultaneous push and pop leave level unchanged
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/txuart_stream.sv
// UART 8N1 transmitter fed by a sample FIFO. Multi-byte samples are sent
// least-significant byte first, frames back to back with no idle gap while
// data remains. tx is registered from the current state, so the line lags
// the FSM by one clock: a pop at edge N puts the start bit on tx at N+1.
module txuart_stream
   import uart_pkg::*;
#(
   parameter int CLOCK_DIVIDE = UART_DEFAULT_DIVIDE,
   parameter int SAMPLE_BYTES = 1,
   parameter int FIFO_AW      = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [8*SAMPLE_BYTES-1:0] in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic                      tx,
   output logic                      busy,
   output logic [FIFO_AW:0]          fifo_level
);

   localparam int SW    = 8 * SAMPLE_BYTES;
   localparam int CNT_W = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;

   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(CLOCK_DIVIDE - 1);
   localparam logic [1:0]       LAST_BYTE = 2'(SAMPLE_BYTES - 1);
   localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

   uart_state_t      state;
   logic [CNT_W-1:0] bit_cnt;
   logic [2:0]       bit_idx;
   logic [1:0]       byte_idx;
   logic [SW-1:0]    sample;
   logic [SW-1:0]    fifo_rd;
   logic [SW-1:0]    sample_shr;
   logic [7:0]       cur_byte;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;
   logic             bit_end;
   logic             more_bytes;
   logic             next_tx;

   assign in_ready = !fifo_full;
   assign push     = in_valid && in_ready;

   sync_fifo #(
      .WIDTH (SW),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .wr_data (in_data),
      .pop     (pop),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // Bit-boundary decode, pop request and the line level for the current state
   always_comb begin
      bit_end    = (bit_cnt == '0);
      more_bytes = (byte_idx != LAST_BYTE);
      pop        = !fifo_empty &&
                   ((state == ST_IDLE) ||
                    (state == ST_STOP && bit_end && !more_bytes));
      sample_shr = sample >> {byte_idx, 3'b000};
      cur_byte   = sample_shr[7:0];
      case (state)
         ST_START: next_tx = START_LEVEL;
         ST_DATA:  next_tx = cur_byte[bit_idx];
         default:  next_tx = STOP_LEVEL;
      endcase
   end

   // Sample holding register, loaded from the FIFO head on every pop
   always_ff @(posedge clk) begin
      if (pop) sample <= fifo_rd;
   end

   // Frame FSM with its bit timer (down-counter reloaded at each bit boundary)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         bit_cnt  <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         tx       <= STOP_LEVEL;
         busy     <= 1'b0;
      end else begin
         tx   <= next_tx;
         busy <= (state != ST_IDLE) || !fifo_empty;
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  byte_idx <= '0;
                  bit_cnt  <= CNT_LOAD;
                  state    <= ST_START;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  bit_cnt <= CNT_LOAD;
                  bit_idx <= '0;
                  state   <= ST_DATA;
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  bit_cnt <= CNT_LOAD;
                  if (bit_idx == LAST_BIT) state <= ST_STOP;
                  else                     bit_idx <= bit_idx + 1'b1;
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  bit_cnt <= CNT_LOAD;
                  if (more_bytes) begin
                     byte_idx <= byte_idx + 1'b1;
                     state    <= ST_START;
                  end else if (!fifo_empty) begin
                     byte_idx <= '0;
                     state    <= ST_START;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
